// File: rtl/fwd_sel_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_unit_pkg
// Brief    : Shared definitions for the EX-stage forwarding-select unit:
//            operand-mux select codes and the default register-address width.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_sel_unit_pkg;

    // Default width of an architectural register address (32 regs, r0 = zero)
    localparam int DEF_REG_AW = 5;

    // Operand-mux select codes seen by the EX stage
    typedef enum logic [2:0] {
        SEL_RF     = 3'd0,  // register file value
        SEL_EXMEM  = 3'd1,  // EX/MEM pipeline result
        SEL_MEMWB  = 3'd2,  // MEM/WB pipeline result
        SEL_WBBUF  = 3'd3,  // retired-WB buffer
        SEL_BUBBLE = 3'd4   // EX slot holds no instruction
    } sel_e;

endpackage : fwd_sel_unit_pkg
`default_nettype wire

// File: rtl/fwd_src_cmp.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_cmp
// Brief    : Compares one source register of the ID instruction against the
//            EX, MEM and WB destination records and returns the forwarding
//            select, nearest stage first. Also reports the raw EX match so
//            the top can detect load-use hazards.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_src_cmp
    import fwd_sel_unit_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic              ex_wen,    // EX record valid and writing
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_wen,   // MEM record valid and writing
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_wen,    // WB record valid and writing
    input  logic [REG_AW-1:0] wb_rd,
    output logic [2:0]        sel,
    output logic              ex_match
);

    logic w_src_nz;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    // r0 is hard-wired zero, so it never matches anything
    assign w_src_nz  = |src;
    assign w_hit_ex  = w_src_nz & ex_wen  & (ex_rd  == src);
    assign w_hit_mem = w_src_nz & mem_wen & (mem_rd == src);
    assign w_hit_wb  = w_src_nz & wb_wen  & (wb_rd  == src);
    assign ex_match  = w_hit_ex;

    // Priority select: the youngest in-flight writer holds the newest value
    always_comb begin
        sel = SEL_RF;
        if (w_hit_ex) begin
            sel = SEL_EXMEM;
        end else if (w_hit_mem) begin
            sel = SEL_MEMWB;
        end else if (w_hit_wb) begin
            sel = SEL_WBBUF;
        end
    end

endmodule : fwd_src_cmp
`default_nettype wire

// File: rtl/fwd_sel_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_unit
// Brief    : Forwarding-select generator for the EX-stage operand muxes.
//            Tracks the destinations of instructions in EX/MEM/WB, registers
//            operand selects for the instruction entering EX, and raises a
//            same-cycle stall on load-use hazards (bubble inserted into EX).
//            Build option FWD_WB_BYPASS_EN: when defined, a WB tracker is
//            kept and WB-distance matches select the retired-WB buffer (3);
//            otherwise the register file is write-before-read and those
//            matches select the register file (0).
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_unit
    import fwd_sel_unit_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [2:0]        sel_a,
    output logic [2:0]        sel_b,
    output logic              stall
);

    // Stage trackers
    logic              r_ex_v;
    logic              r_ex_wr;
    logic              r_ex_ld;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_mem_v;
    logic              r_mem_wr;
    logic [REG_AW-1:0] r_mem_rd;

    logic [2:0]        r_sel_a;
    logic [2:0]        r_sel_b;

    logic              w_wb_wen;
    logic [REG_AW-1:0] w_wb_rd;
    logic [2:0]        w_sel_a;
    logic [2:0]        w_sel_b;
    logic              w_ex_match_a;
    logic              w_ex_match_b;
    logic              w_stall;
    logic              w_adv;

`ifdef FWD_WB_BYPASS_EN
    logic              r_wb_v;
    logic              r_wb_wr;
    logic [REG_AW-1:0] r_wb_rd;

    // WB tracker: follows MEM one cycle later, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_v  <= 1'b0;
            r_wb_wr <= 1'b0;
            r_wb_rd <= '0;
        end else begin
            r_wb_v  <= r_mem_v;
            r_wb_wr <= r_mem_wr;
            r_wb_rd <= r_mem_rd;
        end
    end

    assign w_wb_wen = r_wb_v & r_wb_wr;
    assign w_wb_rd  = r_wb_rd;
`else
    // No WB tracker: the register file already holds WB-distance results
    assign w_wb_wen = 1'b0;
    assign w_wb_rd  = '0;
`endif

    fwd_src_cmp #(
        .REG_AW   (REG_AW)
    ) u_cmp_rs (
        .src      (id_rs),
        .ex_wen   (r_ex_v & r_ex_wr),
        .ex_rd    (r_ex_rd),
        .mem_wen  (r_mem_v & r_mem_wr),
        .mem_rd   (r_mem_rd),
        .wb_wen   (w_wb_wen),
        .wb_rd    (w_wb_rd),
        .sel      (w_sel_a),
        .ex_match (w_ex_match_a)
    );

    fwd_src_cmp #(
        .REG_AW   (REG_AW)
    ) u_cmp_rt (
        .src      (id_rt),
        .ex_wen   (r_ex_v & r_ex_wr),
        .ex_rd    (r_ex_rd),
        .mem_wen  (r_mem_v & r_mem_wr),
        .mem_rd   (r_mem_rd),
        .wb_wen   (w_wb_wen),
        .wb_rd    (w_wb_rd),
        .sel      (w_sel_b),
        .ex_match (w_ex_match_b)
    );

    // A load still in EX cannot feed the ID instruction yet; flush overrides
    assign w_stall = id_valid & ~flush & r_ex_v & r_ex_ld
                   & (w_ex_match_a | w_ex_match_b);
    assign w_adv   = id_valid & ~w_stall & ~flush;
    assign stall   = w_stall;

    // EX/MEM trackers: ID enters EX only when advancing; flush kills EX too
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_v   <= 1'b0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_v  <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_rd <= '0;
        end else begin
            r_ex_v   <= w_adv;
            r_ex_wr  <= id_wr_en;
            r_ex_ld  <= id_is_load;
            r_ex_rd  <= id_rd;
            r_mem_v  <= r_ex_v & ~flush;
            r_mem_wr <= r_ex_wr;
            r_mem_rd <= r_ex_rd;
        end
    end

    // Selects follow the instruction into EX; an empty EX slot reports bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_a <= SEL_BUBBLE;
            r_sel_b <= SEL_BUBBLE;
        end else if (w_adv) begin
            r_sel_a <= w_sel_a;
            r_sel_b <= w_sel_b;
        end else begin
            r_sel_a <= SEL_BUBBLE;
            r_sel_b <= SEL_BUBBLE;
        end
    end

    assign sel_a = r_sel_a;
    assign sel_b = r_sel_b;

endmodule : fwd_sel_unit
`default_nettype wire
